// File: rtl/md5_msg_pack.sv
// Sliding-window packer: emits one padded 512-bit MD5 block per window position.
// Optional MD5_MSG_PACK_NL_MAP_EN maps 0x0A/0x0D to 0x20 before the window.
module md5_msg_pack #(
  parameter int STR_LEN = 19,
  parameter int POS_W   = 16
) (
  input  logic             clk_96mhz,
  input  logic             reset,
  input  logic             start,
  input  logic [POS_W-1:0] num_bytes,
  input  logic [7:0]       data,
  input  logic             data_valid,
  output logic [511:0]     m_out,
  output logic             valid_out,
  output logic [POS_W-1:0] byte_pos,
  output logic             busy,
  output logic             done
);

  localparam int          WIN_W   = STR_LEN * 8;
  localparam logic [63:0] BIT_LEN = 64'(STR_LEN * 8);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } state_t;

  state_t             state;
  logic [WIN_W-1:0]   win;
  logic [WIN_W-1:0]   win_next;
  logic [5:0]         fill;
  logic [POS_W-1:0]   cnt;
  logic [POS_W-1:0]   num_lat;
  logic [7:0]         in_byte;
  logic               full_next;
  logic               last;
  logic [511:0]       msg;

`ifdef MD5_MSG_PACK_NL_MAP_EN
  always_comb begin
    in_byte = data;
    if (data == 8'h0A || data == 8'h0D)
      in_byte = 8'h20;
  end
`else
  always_comb in_byte = data;
`endif

  // Newest byte enters at the top so byte 0 is always the oldest.
  generate
    if (STR_LEN == 1) begin : g_one
      assign win_next = in_byte;
    end else begin : g_many
      assign win_next = {in_byte, win[WIN_W-1:8]};
    end
  endgenerate

  assign full_next = (state == STREAM) ||
                     (fill == 6'(STR_LEN - 1));
  assign last      = (POS_W'(cnt + 1'b1) == num_lat);

  always_comb begin
    msg              = '0;
    msg[WIN_W-1:0]   = win_next;
    msg[WIN_W +: 8]  = 8'h80;
    msg[511:448]     = BIT_LEN;
  end

  always_ff @(posedge clk_96mhz) begin
    if (reset) begin
      state     <= IDLE;
      win       <= '0;
      fill      <= '0;
      cnt       <= '0;
      num_lat   <= '0;
      m_out     <= '0;
      valid_out <= 1'b0;
      byte_pos  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      done      <= 1'b0;
      if (start) begin
        num_lat <= num_bytes;
        cnt     <= '0;
        fill    <= '0;
        win     <= '0;
        if (num_bytes == '0) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= FILL;
          busy  <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          FILL, STREAM: begin
            if (data_valid) begin
              win <= win_next;
              cnt <= cnt + 1'b1;
              if (fill != 6'(STR_LEN))
                fill <= fill + 1'b1;
              if (full_next) begin
                valid_out <= 1'b1;
                m_out     <= msg;
                byte_pos  <= cnt - POS_W'(STR_LEN - 1);
              end
              if (last) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (full_next) begin
                state <= STREAM;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md5_msg_pack.sv
// Directed bench for md5_msg_pack: vector table plus reset/restart/newline runs.
module tb_md5_msg_pack;

  logic         clk_96mhz = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  num_bytes;
  logic [7:0]   data;
  logic         data_valid;
  logic [511:0] m_out;
  logic         valid_out;
  logic [15:0]  byte_pos;
  logic         busy;
  logic         done;

  md5_msg_pack dut (
    .clk_96mhz  (clk_96mhz),
    .reset      (reset),
    .start      (start),
    .num_bytes  (num_bytes),
    .data       (data),
    .data_valid (data_valid),
    .m_out      (m_out),
    .valid_out  (valid_out),
    .byte_pos   (byte_pos),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_96mhz = ~clk_96mhz;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk_96mhz) cyc++;

  logic [511:0] msg_q[$];
  int           pos_q[$];
  int           done_n;
  int           done_cyc;
  int           vld_cyc;
  int           drv_cyc[64];
  int           st_cyc;

  always @(negedge clk_96mhz) begin
    if (valid_out) begin
      msg_q.push_back(m_out);
      pos_q.push_back(int'(byte_pos));
      vld_cyc = cyc;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  typedef struct {
    int nbytes;
    int nsend;
    int gaps;
    int blocks;
  } vec_t;

  task automatic chk(input string name, input logic [511:0] got,
                     input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] dbyte(input int sel, input int i);
    logic [7:0] b;
    if (sel == 1)
      b = 8'h41 + 8'(i % 26);
    else
      b = 8'h61 + 8'(i % 26);
    if (sel == 2 && i == 4)
      b = 8'h0A;
`ifdef MD5_MSG_PACK_NL_MAP_EN
    if (b == 8'h0A || b == 8'h0D)
      b = 8'h20;
`endif
    return b;
  endfunction

  function automatic logic [7:0] raw(input int sel, input int i);
    if (sel == 2 && i == 4)
      return 8'h0A;
    if (sel == 1)
      return 8'h41 + 8'(i % 26);
    return 8'h61 + 8'(i % 26);
  endfunction

  function automatic logic [511:0] model(input int sel, input int first);
    logic [511:0] m;
    m = '0;
    for (int k = 0; k < 19; k++)
      m[8*k +: 8] = dbyte(sel, first + k);
    m[8*19 +: 8] = 8'h80;
    m[448 +: 8]  = 8'h98;
    return m;
  endfunction

  task automatic step();
    @(posedge clk_96mhz);
    #1;
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_bytes = 16'(n);
    st_cyc    = cyc;
    step();
    start     = 1'b0;
  endtask

  task automatic send(input int n, input int gaps, input int sel);
    for (int i = 0; i < n; i++) begin
      if (gaps != 0) begin
        data_valid = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
      data_valid = 1'b1;
      data       = raw(sel, i);
      drv_cyc[i] = cyc;
      step();
    end
    data_valid = 1'b0;
  endtask

  task automatic clear_mon();
    msg_q.delete();
    pos_q.delete();
    done_n   = 0;
    done_cyc = -1;
    vld_cyc  = -1;
  endtask

  vec_t vecs[5];
  int   exp_done;

  initial begin
    vecs[0] = '{nbytes: 19, nsend: 19, gaps: 0, blocks: 1};
    vecs[1] = '{nbytes: 21, nsend: 21, gaps: 1, blocks: 3};
    vecs[2] = '{nbytes: 5,  nsend: 5,  gaps: 0, blocks: 0};
    vecs[3] = '{nbytes: 0,  nsend: 0,  gaps: 0, blocks: 0};
    vecs[4] = '{nbytes: 24, nsend: 26, gaps: 0, blocks: 6};

    reset      = 1'b1;
    start      = 1'b0;
    num_bytes  = '0;
    data       = '0;
    data_valid = 1'b0;
    clear_mon();
    step();
    step();
    reset = 1'b0;
    chk("rst_m_out", m_out, '0);
    chk("rst_valid", 512'(valid_out), '0);
    chk("rst_pos", 512'(byte_pos), '0);
    chk("rst_busy", 512'(busy), '0);
    chk("rst_done", 512'(done), '0);

    for (int v = 0; v < 5; v++) begin
      clear_mon();
      do_start(vecs[v].nbytes);
      if (vecs[v].nbytes != 0)
        chk($sformatf("v%0d_busy", v), 512'(busy), 512'(1));
      send(vecs[v].nsend, vecs[v].gaps, 0);
      repeat (4) step();
      chk($sformatf("v%0d_blocks", v), 512'(pos_q.size()),
          512'(vecs[v].blocks));
      for (int i = 0; i < pos_q.size(); i++) begin
        chk($sformatf("v%0d_pos%0d", v, i), 512'(pos_q[i]), 512'(i));
        chk($sformatf("v%0d_msg%0d", v, i), msg_q[i], model(0, i));
      end
      chk($sformatf("v%0d_done_n", v), 512'(done_n), 512'(1));
      exp_done = (vecs[v].nbytes == 0) ? st_cyc + 1 :
                 drv_cyc[vecs[v].nbytes-1] + 1;
      chk($sformatf("v%0d_done_cyc", v), 512'(done_cyc), 512'(exp_done));
      if (vecs[v].blocks > 0)
        chk($sformatf("v%0d_vld_cyc", v), 512'(vld_cyc), 512'(exp_done));
      chk($sformatf("v%0d_idle", v), 512'(busy), '0);
      if (v == 0 && msg_q.size() > 0) begin
        chk("v0_b0", 512'(msg_q[0][7:0]), 512'(8'h61));
        chk("v0_b18", 512'(msg_q[0][151:144]), 512'(8'h73));
        chk("v0_pad80", 512'(msg_q[0][159:152]), 512'(8'h80));
        chk("v0_len", 512'(msg_q[0][455:448]), 512'(8'h98));
        chk("v0_zero", 512'(msg_q[0][447:160]), '0);
      end
      if (v == 1 && msg_q.size() > 2) begin
        chk("v1_b0", 512'(msg_q[2][7:0]), 512'(8'h63));
        chk("v1_b18", 512'(msg_q[2][151:144]), 512'(8'h75));
      end
    end

    // Reset in the middle of a run.
    clear_mon();
    do_start(30);
    send(23, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_m_out", m_out, '0);
    chk("mrst_valid", 512'(valid_out), '0);
    chk("mrst_pos", 512'(byte_pos), '0);
    chk("mrst_busy", 512'(busy), '0);
    chk("mrst_done", 512'(done), '0);
    repeat (3) step();
    chk("mrst_no_done", 512'(done_n), '0);
    clear_mon();
    do_start(19);
    send(19, 0, 0);
    repeat (3) step();
    chk("mrst2_blocks", 512'(pos_q.size()), 512'(1));
    if (pos_q.size() > 0) begin
      chk("mrst2_pos", 512'(pos_q[0]), '0);
      chk("mrst2_msg", msg_q[0], model(0, 0));
    end
    chk("mrst2_done_n", 512'(done_n), 512'(1));

    // Restart while busy; same-cycle data must be dropped.
    clear_mon();
    do_start(40);
    send(26, 0, 0);
    start      = 1'b1;
    num_bytes  = 16'd20;
    data_valid = 1'b1;
    data       = 8'hFF;
    step();
    start      = 1'b0;
    data_valid = 1'b0;
    msg_q.delete();
    pos_q.delete();
    chk("rs_no_done", 512'(done_n), '0);
    send(20, 0, 1);
    repeat (3) step();
    chk("rs_blocks", 512'(pos_q.size()), 512'(2));
    for (int i = 0; i < pos_q.size(); i++) begin
      chk($sformatf("rs_pos%0d", i), 512'(pos_q[i]), 512'(i));
      chk($sformatf("rs_msg%0d", i), msg_q[i], model(1, i));
    end
    chk("rs_done_n", 512'(done_n), 512'(1));

    // Line-feed inside the window.
    clear_mon();
    do_start(19);
    send(19, 0, 2);
    repeat (3) step();
    chk("nl_blocks", 512'(pos_q.size()), 512'(1));
    if (pos_q.size() > 0) begin
      chk("nl_pos", 512'(pos_q[0]), '0);
`ifdef MD5_MSG_PACK_NL_MAP_EN
      chk("nl_b4", 512'(msg_q[0][39:32]), 512'(8'h20));
`else
      chk("nl_b4", 512'(msg_q[0][39:32]), 512'(8'h0A));
`endif
      chk("nl_msg", msg_q[0], model(2, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md5_msg_pack.md
Name: md5_msg_pack

Overview:
- Upstream feeder for the string processing/match stage.
- Takes the byte stream that cmd_parser forwards, keeps a sliding window of the last STR_LEN characters, and emits one fully padded 512-bit MD5 message block per window position.
- Each block carries the 0-based byte position of its first character, which the match stage reports on a hash hit.

Parameters:
- STR_LEN, 19, characters per hashed string; legal range 1..55 so that the pad and length fields fit in one block.
- POS_W, 16, width of byte count and position fields.

Ports:
- clk_96mhz  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a run and latches num_bytes.
- num_bytes  input  POS_W  total bytes in this run.
- data  input  8  character byte.
- data_valid  input  1  data is valid this cycle. No backpressure: the downstream MD5 core is fully pipelined.
- m_out  output  512  padded message block; byte k sits at m_out[8k+7:8k].
- valid_out  output  1  m_out/byte_pos are valid, one-cycle pulse.
- byte_pos  output  POS_W  stream index of the first character in m_out.
- busy  output  1  a run is in progress.
- done  output  1  one-cycle pulse when the run completes.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - m_out=0, valid_out=0, byte_pos=0, busy=0, done=0.
  - Window, fill counter, byte counter and latched num_bytes all clear.
- States and transitions:
  - IDLE -> FILL on start.
  - FILL -> STREAM when the STR_LEN-th byte is accepted.
  - FILL or STREAM -> DONE when the byte count reaches the latched num_bytes.
  - DONE -> IDLE after one cycle.
  - busy=1 in FILL and STREAM.
- On start:
  - Latch num_bytes.
  - Clear byte counter, fill counter and window.
- start while busy:
  - Aborts the current run; no done pulse for the aborted run.
  - Restarts as above; any data_valid in that same cycle is ignored.
- Accepting bytes:
  - A byte is accepted when data_valid=1 in FILL or STREAM.
  - Accepted byte shifts into the window; the oldest character drops.
  - data_valid in IDLE or DONE is ignored.
  - Gaps in data_valid are allowed; state holds.
- Message layout, combinational from the window into the output register:
  - Bytes 0..STR_LEN-1 = window, oldest first.
  - Byte STR_LEN = 0x80.
  - Bytes STR_LEN+1..55 = 0x00.
  - Bytes 56..63 = bit length STR_LEN*8, 64-bit little-endian. For 19 this is byte56=0x98, rest 0.
- Output timing:
  - valid_out rises the cycle after a byte is accepted, provided that byte makes the window full, i.e. it is the STR_LEN-th or a later byte.
  - byte_pos for that block = (accepted byte index) - (STR_LEN-1), arithmetic modulo 2^POS_W.
  - m_out and byte_pos hold their value between pulses.
- Completion:
  - done pulses the cycle after the byte that makes count == num_bytes is accepted, i.e. the same cycle as the final valid_out.
  - num_bytes=0: done pulses the cycle after start, with no blocks.
  - 0 < num_bytes < STR_LEN: all bytes are consumed, no valid_out is produced, and done pulses after the last byte.
  - Blocks per run = max(0, num_bytes-STR_LEN+1).
- Extra bytes after the count is reached (DONE/IDLE) are ignored.
- start and reset in the same cycle: reset wins.

Optional Feature:
- MD5_MSG_PACK_NL_MAP_EN defined:
  - Bytes 0x0A and 0x0D are replaced by 0x20 before entering the window.
  - byte_pos counting is unchanged.
- Undefined: all bytes enter the window unmodified.

Test Plan:
- num_bytes=19, stream "abcdefghijklmnopqrs", data_valid held high:
  - Exactly one valid_out, on the cycle after "s", with byte_pos=0.
  - m_out[7:0]=0x61, m_out[151:144]=0x73, m_out[159:152]=0x80, m_out[455:448]=0x98, all other pad bytes 0.
  - done is asserted in the same cycle.
- num_bytes=21, stream "abcdefghijklmnopqrstu" with random 1-3 cycle data_valid gaps:
  - Three valid_out pulses, byte_pos 0,1,2.
  - Third block's byte0=0x63 ('c') and byte18=0x75 ('u').
  - done with the last pulse.
- num_bytes=5 (five bytes), then separately num_bytes=0:
  - No valid_out in either case.
  - done pulses 1 cycle after the 5th byte, and 1 cycle after start respectively.
- Run with num_bytes=30; reset asserted after byte 22:
  - All outputs 0 the next cycle and no done.
  - A fresh start with num_bytes=19 then yields byte_pos=0 and correct data.
- Run with num_bytes=40; start (num_bytes=20) reissued after byte 25:
  - No done for the first run.
  - New run yields exactly two blocks, byte_pos 0 and 1, from the new data only.
- With MD5_MSG_PACK_NL_MAP_EN: stream of 19 bytes containing 0x0A at index 4:
  - m_out[39:32]=0x20, byte_pos=0.
- Without MD5_MSG_PACK_NL_MAP_EN, same stream:
  - m_out[39:32]=0x0A.
